// File: rtl/psum_writeback_if.sv
// -----------------------------------------------------------------------------
// psum_writeback_if
// Groups the job-control, OFIFO and psum-SRAM signals of the partial-sum
// writeback engine.
//   master : the writeback engine (drives ofifo_rd, SRAM controls, busy, done)
//   slave  : the surroundings (job launcher, OFIFO, SRAM)
// Signals:
//   start / acc_en / base_addr / num_words : job launch and job parameters
//   ofifo_valid / ofifo_dout / ofifo_rd    : OFIFO head and pop
//   sram_cen / sram_wen (active-low), sram_a, sram_d, sram_q : psum SRAM port
//   busy / done                            : job status
// -----------------------------------------------------------------------------
interface psum_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
);
  logic                     start;
  logic                     acc_en;
  logic [addr_w-1:0]        base_addr;
  logic [addr_w-1:0]        num_words;
  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_dout;
  logic                     ofifo_rd;
  logic                     sram_cen;
  logic                     sram_wen;
  logic [addr_w-1:0]        sram_a;
  logic [col*psum_bw-1:0]   sram_d;
  logic [col*psum_bw-1:0]   sram_q;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, acc_en, base_addr, num_words, ofifo_valid, ofifo_dout, sram_q,
    output ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done
  );

  modport slave (
    output start, acc_en, base_addr, num_words, ofifo_valid, ofifo_dout, sram_q,
    input  ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done
  );
endinterface

// File: rtl/psum_writeback.sv
// -----------------------------------------------------------------------------
// psum_writeback
// Drains partial-sum rows from the OFIFO into the psum SRAM, either as a plain
// overwrite (one word per cycle) or as a read-add-write accumulation with
// per-lane signed saturation (three cycles per word).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : psum_writeback_if.master (job control, OFIFO, SRAM, status)
// -----------------------------------------------------------------------------
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  psum_writeback_if.master     bus
);

  localparam int W = col * psum_bw;
  localparam logic signed [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_RDOLD = 3'd2,
    S_WRSUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_acc;
  logic [addr_w-1:0] r_base;
  logic [addr_w-1:0] r_num;
  logic [addr_w-1:0] r_cnt;
  logic [W-1:0]      r_hold;
  logic [W-1:0]      r_old;

  logic [addr_w-1:0] w_addr;
  logic [addr_w-1:0] w_cnt_inc;
  logic              w_last;
  logic [W-1:0]      w_sum;

  // One extra bit catches overflow: the two top bits disagree only when the
  // true sum is out of range, and the top bit then gives the direction.
  function automatic logic signed [psum_bw-1:0] sat_add_lane(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
    logic signed [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? LANE_MIN : LANE_MAX;
    return s[psum_bw-1:0];
  endfunction

  function automatic logic [W-1:0] sat_add_word(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < col; i++)
      r[i*psum_bw +: psum_bw] = sat_add_lane(a[i*psum_bw +: psum_bw],
                                             b[i*psum_bw +: psum_bw]);
    return r;
  endfunction

  // Address wraps naturally at addr_w bits.
  assign w_addr    = r_base + r_cnt;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == r_num);
  assign w_sum     = sat_add_word(r_hold, r_old);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (bus.num_words == '0) ? S_DONE : S_XFER;
      S_XFER:  if (bus.ofifo_valid) begin
                 if (r_acc)       w_next = S_RDOLD;
                 else if (w_last) w_next = S_DONE;
               end
      S_RDOLD: w_next = S_WRSUM;
      S_WRSUM: w_next = w_last ? S_DONE : S_XFER;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only (plus OFIFO valid in XFER), so an
  // asynchronous reset forces them to their idle values immediately.
  always_comb begin
    bus.ofifo_rd = 1'b0;
    bus.sram_cen = 1'b1;
    bus.sram_wen = 1'b1;
    bus.sram_a   = '0;
    bus.sram_d   = '0;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = 1'b0;
    case (r_state)
      S_XFER: begin
        bus.sram_a = w_addr;
        if (bus.ofifo_valid) begin
          bus.ofifo_rd = 1'b1;
          bus.sram_cen = 1'b0;
          bus.sram_wen = r_acc;     // accumulate reads the old value first
          bus.sram_d   = r_acc ? '0 : bus.ofifo_dout;
        end
      end
      S_RDOLD: bus.sram_a = w_addr;
      S_WRSUM: begin
        bus.sram_cen = 1'b0;
        bus.sram_wen = 1'b0;
        bus.sram_a   = w_addr;
        bus.sram_d   = w_sum;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Job registers and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc  <= 1'b0;
      r_base <= '0;
      r_num  <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_old  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_acc  <= bus.acc_en;
          r_base <= bus.base_addr;
          r_num  <= bus.num_words;
          r_cnt  <= '0;
        end
        S_XFER: if (bus.ofifo_valid) begin
          if (r_acc) r_hold <= bus.ofifo_dout;
          else       r_cnt  <= w_cnt_inc;
        end
        S_RDOLD: r_old <= bus.sram_q;   // read issued in XFER returns now
        S_WRSUM: r_cnt <= w_cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 Parameter col, default 8, number of psum lanes per word.
REQ-002 Parameter psum_bw, default 16, bits per signed psum lane.
REQ-003 Parameter addr_w, default 11, psum SRAM address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  in  1  one-cycle pulse that launches a drain job; sampled only in IDLE.
REQ-007 acc_en  in  1  1 = read-add-write into SRAM, 0 = plain overwrite; latched at start.
REQ-008 base_addr  in  addr_w  first SRAM address of the job; latched at start.
REQ-009 num_words  in  addr_w  words to drain; latched at start; 0 means an empty job.
REQ-010 ofifo_valid  in  1  OFIFO holds at least one full row; ofifo_dout is valid combinationally.
REQ-011 ofifo_dout  in  col*psum_bw  OFIFO head word; lane i is bits [i*psum_bw +: psum_bw].
REQ-012 ofifo_rd  out  1  pops the OFIFO head at the clock edge.
REQ-013 sram_cen  out  1  SRAM chip enable, active-low.
REQ-014 sram_wen  out  1  SRAM write enable, active-low (1 = read).
REQ-015 sram_a  out  addr_w  SRAM address.
REQ-016 sram_d  out  col*psum_bw  SRAM write data.
REQ-017 sram_q  in  col*psum_bw  SRAM read data, valid one cycle after a read cycle.
REQ-018 busy  out  1  high in every state other than IDLE.
REQ-019 done  out  1  one-cycle pulse when the job completes.

Function
REQ-020 The FSM SHALL have the states IDLE, XFER, RDOLD, WRSUM and DONE.
REQ-021 IDLE with start=1: latch acc_en, base_addr and num_words; clear cnt; go to DONE if num_words==0, otherwise go to XFER.
REQ-022 XFER with ofifo_valid=0: hold; drive ofifo_rd=0 and sram_cen=1.
REQ-023 XFER with ofifo_valid=1 and acc_en=0, in one cycle:
  - drive ofifo_rd=1, sram_cen=0, sram_wen=0;
  - drive sram_a=base_addr+cnt and sram_d=ofifo_dout;
  - increment cnt.
REQ-024 XFER with ofifo_valid=1 and acc_en=1, in one cycle:
  - drive ofifo_rd=1, sram_cen=0, sram_wen=1, sram_a=base_addr+cnt;
  - capture ofifo_dout into hold_reg;
  - go to RDOLD.
REQ-025 RDOLD SHALL drive sram_cen=1 and ofifo_rd=0, register sram_q into old_reg, and go to WRSUM.
REQ-026 WRSUM SHALL drive the following, then increment cnt:
  - sram_cen=0, sram_wen=0, sram_a=base_addr+cnt;
  - sram_d = lane-wise saturating signed sum of hold_reg and old_reg.
REQ-027 Saturation, per lane: clamp to 2^(psum_bw-1)-1 on positive overflow and to -2^(psum_bw-1) on negative overflow; lanes are independent.
REQ-028 After the increment in XFER or WRSUM, go to DONE when cnt reaches num_words; otherwise return to XFER.
REQ-029 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-030 Address arithmetic SHALL wrap modulo 2^addr_w.
REQ-031 start SHALL be ignored when busy=1.
REQ-032 ofifo_rd SHALL never assert while ofifo_valid=0, and SHALL pop at most one word per cycle.
REQ-033 Overwrite-mode throughput SHALL be one word per cycle when ofifo_valid stays high; accumulate mode SHALL take 3 cycles per word.
REQ-034 sram_d SHALL be don't-care whenever sram_wen=1 or sram_cen=1.

Reset
REQ-035 While reset=0, outputs SHALL take these values immediately, independent of clk:
  - state=IDLE, cnt=0, hold_reg=0, old_reg=0;
  - ofifo_rd=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0, busy=0, done=0.
REQ-036 Reset asserted mid-job SHALL abort the job with no further SRAM write or OFIFO pop; the partially written SRAM content is left as is.

Verification
REQ-037 Overwrite: base_addr=5, num_words=3, ofifo_valid held high with words W0..W2 -> writes to addresses 5, 6, 7 on 3 consecutive cycles; done pulses on the 4th cycle after start.
REQ-038 Stall: ofifo_valid=0 for 4 cycles mid-job -> no ofifo_rd, sram_cen=1 throughout, busy=1; the job resumes at the correct address.
REQ-039 Accumulate: SRAM[10] lane0=100, ofifo lane0=-30, acc_en=1 -> SRAM[10] lane0=70; other lanes are summed independently.
REQ-040 Saturation: old=32000, new=1000 -> 32767; old=-32000, new=-1000 -> -32768 (psum_bw=16).
REQ-041 Boundaries:
  - num_words=0 -> done on the cycle after start, no SRAM access;
  - base_addr=2046, num_words=4 -> writes addresses 2046, 2047, 0, 1.
REQ-042 Reset: reset=0 asserted asynchronously between an RDOLD and a WRSUM cycle -> outputs return to their reset values within the same cycle, no write occurs, and busy=0.
